// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, reservation and register-file write bundle
interface regfile_wb_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
);
    // Writeback requesters: one valid/ready pair per requester, packed address and data
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;

    // Destination reservation from decode for multi-cycle operations
    logic                        rsv_valid;
    logic [ADDR_WIDTH-1:0]       rsv_addr;
    logic                        rsv_conflict;

    // Registered register-file write port
    logic                        rf_we;
    logic [ADDR_WIDTH-1:0]       rf_waddr;
    logic [DATA_WIDTH-1:0]       rf_wdata;

    // Pending-write scoreboard used for hazard stalls
    logic [NUM_REGS-1:0]         busy;

    // Requester / decode side
    modport master (
        output req_valid, req_addr, req_data, rsv_valid, rsv_addr,
        input  req_ready, rf_we, rf_waddr, rf_wdata, busy, rsv_conflict
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_data, rsv_valid, rsv_addr,
        output req_ready, rf_we, rf_waddr, rf_wdata, busy, rsv_conflict
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with destination busy scoreboard
module regfile_wb_arbiter #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Round-robin state: the requester searched first on the next cycle
    logic [PTR_W-1:0]      rr_ptr;

    // Arbitration results
    logic [N_REQ-1:0]      grant;
    logic                  xfer;
    int                    gsel;
    logic [PTR_W-1:0]      next_ptr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_nonzero;

    // Scoreboard update terms
    logic                  rsv_hit;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   clr_mask;
    logic                  rsv_clearing;

    // Registered outputs
    logic                  rf_we_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;
    logic [NUM_REGS-1:0]   busy_q;
    logic                  conflict_q;

    // Search upward from rr_ptr (mod N_REQ) for the first valid requester
    always_comb begin
        grant = '0;
        xfer  = 1'b0;
        gsel  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!xfer && bus.req_valid[idx]) begin
                xfer = 1'b1;
                gsel = idx;
            end
        end
        if (xfer) begin
            grant[gsel] = 1'b1;
        end
        next_ptr = PTR_W'((gsel + 1) % N_REQ);
    end

    // Mux the winner's address and data; x0 writes are accepted but never issued
    always_comb begin
        sel_addr    = bus.req_addr[gsel*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data    = bus.req_data[gsel*DATA_WIDTH +: DATA_WIDTH];
        sel_nonzero = (sel_addr != '0);
    end

    // Scoreboard set/clear masks; set beats clear when both hit the same register
    always_comb begin
        set_mask     = '0;
        clr_mask     = '0;
        rsv_hit      = bus.rsv_valid && (bus.rsv_addr != '0);
        rsv_clearing = xfer && sel_nonzero && (sel_addr == bus.rsv_addr);
        if (rsv_hit) begin
            set_mask[bus.rsv_addr] = 1'b1;
        end
        if (xfer && sel_nonzero) begin
            clr_mask[sel_addr] = 1'b1;
        end
    end

    // Pointer and registered write port; addr/data hold when nothing transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= xfer && sel_nonzero;
            if (xfer) begin
                rr_ptr     <= next_ptr;
                rf_waddr_q <= sel_addr;
                rf_wdata_q <= sel_data;
            end
        end
    end

    // Busy scoreboard and reservation-conflict pulse; bit 0 can never be set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            busy_q     <= (busy_q & ~clr_mask) | set_mask;
            conflict_q <= rsv_hit && busy_q[bus.rsv_addr] && !rsv_clearing;
        end
    end

    assign bus.req_ready    = grant;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.busy         = busy_q;
    assign bus.rsv_conflict = conflict_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int N_REQ      = 2;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_wb_arbiter_if #(
        .N_REQ(N_REQ), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)
    ) bus ();

    regfile_wb_arbiter #(
        .N_REQ(N_REQ), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1);
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
        #1;
    endtask

    task automatic set_rsv(input logic v, input logic [4:0] a);
        bus.rsv_valid = v;
        bus.rsv_addr  = a;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = '0;
        #2;
        check("rst_we",       bus.rf_we,        0);
        check("rst_waddr",    bus.rf_waddr,     0);
        check("rst_wdata",    bus.rf_wdata,     0);
        check("rst_busy",     bus.busy,         0);
        check("rst_conflict", bus.rsv_conflict, 0);
        #6 rst = 1'b0;

        // Both requesters valid for four cycles: grants alternate starting at 0
        set_req(2'b11, 5'd3, 32'hAAAA0000, 5'd7, 32'h5555FFFF);
        check("rr_ready0", bus.req_ready, 2'b01);
        step();
        check("rr_we1",    bus.rf_we,    1);
        check("rr_waddr1", bus.rf_waddr, 3);
        check("rr_wdata1", bus.rf_wdata, 64'hAAAA0000);
        check("rr_ready1", bus.req_ready, 2'b10);
        step();
        check("rr_waddr2", bus.rf_waddr, 7);
        check("rr_wdata2", bus.rf_wdata, 64'h5555FFFF);
        check("rr_ready2", bus.req_ready, 2'b01);
        step();
        check("rr_waddr3", bus.rf_waddr, 3);
        check("rr_ready3", bus.req_ready, 2'b10);
        step();
        check("rr_waddr4", bus.rf_waddr, 7);
        check("rr_we4",    bus.rf_we,    1);

        // Requester 1 alone writes x0: accepted, discarded, pointer wraps to 0
        set_req(2'b10, 5'd3, 32'hAAAA0000, 5'd0, 32'hDEADBEEF);
        check("x0_ready", bus.req_ready, 2'b10);
        step();
        check("x0_we",    bus.rf_we,    0);
        check("x0_waddr", bus.rf_waddr, 0);
        check("x0_wdata", bus.rf_wdata, 64'hDEADBEEF);
        set_req(2'b11, 5'd3, 32'hAAAA0000, 5'd0, 32'hDEADBEEF);
        check("x0_ptr_wrap", bus.req_ready, 2'b01);
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        check("idle_ready", bus.req_ready, 2'b00);
        step();
        check("idle_we",    bus.rf_we,    0);
        check("idle_waddr", bus.rf_waddr, 0);

        // Reserve 9, then requester 0 writes 9 and clears it on the write edge
        set_rsv(1'b1, 5'd9);
        step();
        check("rsv9_busy", bus.busy, 32'h0000_0200);
        check("rsv9_conf", bus.rsv_conflict, 0);
        set_rsv(1'b0, 5'd0);
        set_req(2'b01, 5'd9, 32'h0000_1234, 5'd0, 32'h0);
        step();
        check("clr9_busy",  bus.busy, 0);
        check("clr9_we",    bus.rf_we, 1);
        check("clr9_waddr", bus.rf_waddr, 9);
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

        // Re-reserve 9, then reserve again on the edge its write lands: set wins, no conflict
        set_rsv(1'b1, 5'd9);
        step();
        check("rsv9b_busy", bus.busy, 32'h0000_0200);
        set_req(2'b01, 5'd9, 32'h0000_5678, 5'd0, 32'h0);
        step();
        check("setwin_busy", bus.busy, 32'h0000_0200);
        check("setwin_conf", bus.rsv_conflict, 0);
        check("setwin_we",   bus.rf_we, 1);
        set_rsv(1'b0, 5'd0);
        step();
        check("clr9b_busy", bus.busy, 0);
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

        // Reserving x0 is ignored
        set_rsv(1'b1, 5'd0);
        step();
        check("rsv0_busy", bus.busy, 0);
        check("rsv0_conf", bus.rsv_conflict, 0);

        // Reserve 12 twice: conflict pulses exactly once
        set_rsv(1'b1, 5'd12);
        step();
        check("rsv12a_conf", bus.rsv_conflict, 0);
        step();
        check("rsv12b_conf", bus.rsv_conflict, 1);
        check("rsv12b_busy", bus.busy, 32'h0000_1000);
        set_rsv(1'b0, 5'd0);
        step();
        check("rsv12c_conf", bus.rsv_conflict, 0);
        check("rsv12c_busy", bus.busy, 32'h0000_1000);

        // Build busy=0x1200 with a write in flight, then assert reset mid-cycle
        set_rsv(1'b1, 5'd9);
        set_req(2'b11, 5'd3, 32'hAAAA0000, 5'd7, 32'h5555FFFF);
        step();
        check("pre_rst_busy", bus.busy, 32'h0000_1200);
        check("pre_rst_we",   bus.rf_we, 1);
        set_rsv(1'b0, 5'd0);
        #1 rst = 1'b1;
        #1;
        check("async_we",    bus.rf_we, 0);
        check("async_busy",  bus.busy, 0);
        check("async_waddr", bus.rf_waddr, 0);
        step();
        check("held_we", bus.rf_we, 0);
        #3 rst = 1'b0;
        #1;
        check("post_rst_ready", bus.req_ready, 2'b01);
        step();
        check("post_rst_waddr", bus.rf_waddr, 3);
        check("post_rst_we",    bus.rf_we, 1);
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between N_REQ writeback requesters, for example the ALU writeback and a multi-cycle load/mul unit. Arbitration is round-robin with a valid/ready handshake. The winning write is registered and driven to the register file one cycle later. The block also keeps a busy scoreboard of destination registers reserved by multi-cycle operations, which decode uses for hazard stalls.

Parameters:
N_REQ, 2, number of writeback requesters (2..4)
ADDR_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width
NUM_REGS, 32, number of architectural registers (2**ADDR_WIDTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid_i  input  N_REQ  per-requester write request valid
req_ready_o  output  N_REQ  per-requester grant; transfer occurs when valid&ready
req_addr_i  input  N_REQ*ADDR_WIDTH  packed destination addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data_i  input  N_REQ*DATA_WIDTH  packed write data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
rsv_valid_i  input  1  reserve a destination register for an in-flight multi-cycle op
rsv_addr_i  input  ADDR_WIDTH  register to reserve
rf_we_o  output  1  register-file write enable (registered)
rf_waddr_o  output  ADDR_WIDTH  register-file write address (registered)
rf_wdata_o  output  DATA_WIDTH  register-file write data (registered)
busy_o  output  NUM_REGS  scoreboard; bit r=1 means register r has a pending write
rsv_conflict_o  output  1  one-cycle pulse: reserve hit an already-busy register

Behaviour:
- Reset (async, rst=1): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, busy_o=0, rsv_conflict_o=0, rr_ptr=0.
  - Pending requests are dropped; no write is issued during or on release of reset.
  - The first arbitration after reset gives priority to requester 0.
- Arbitration (combinational):
  - Search from rr_ptr upward modulo N_REQ; grant the first requester with req_valid_i set.
  - req_ready_o is one-hot or zero. It depends combinationally on req_valid_i; requesters must not make valid depend on ready.
  - At most one transfer per cycle; there is no backpressure from the register file.
- Pointer update (on an edge with a transfer by requester g): rr_ptr <= (g+1) mod N_REQ. No transfer leaves rr_ptr unchanged.
- Write output (1-cycle latency):
  - On a transfer edge: rf_waddr_o<=addr_g, rf_wdata_o<=data_g, rf_we_o<=(addr_g!=0).
  - On a no-transfer edge: rf_we_o<=0; addr/data hold their previous values.
  - A write to x0 is accepted (ready asserted) but discarded (rf_we_o=0).
- Scoreboard:
  - Set: an edge with rsv_valid_i=1 and rsv_addr_i!=0 sets busy[rsv_addr_i].
  - Clear: an edge with a transfer to addr_g!=0 clears busy[addr_g]. The clear lands on the same edge that raises rf_we_o.
  - Set and clear of the same register on the same edge: set wins, and busy stays 1.
  - busy_o[0] is constant 0; reserving x0 is ignored.
  - A requester write to a non-busy register is legal and leaves busy unchanged.
- Conflict:
  - rsv_conflict_o<=1 for one cycle when rsv_valid_i=1, rsv_addr_i!=0, busy[rsv_addr_i]=1, and the register is not being cleared on that edge.
  - Otherwise rsv_conflict_o<=0. The reservation is still applied (busy stays 1).
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once every N_REQ cycles.
- Outputs: all outputs except req_ready_o are registered.

Test Plan:
- Reset, then req_valid_i=2'b11, addr0=3/data0=0xAAAA0000, addr1=7/data1=0x5555FFFF, held 4 cycles -> grant order 0,1,0,1; rf_we_o=1 from cycle 1; rf_waddr_o sequence 3,7,3,7.
- Only requester 1 valid, addr=0, data=0xDEADBEEF -> req_ready_o=2'b10; next cycle rf_we_o=0; rr_ptr advances to 0.
- rsv_valid_i with addr 9 -> busy_o[9]=1 next cycle; a later transfer to addr 9 -> busy_o[9]=0 and rf_we_o=1 on the same edge.
- Reserve addr 9 again on the same edge as the requester's write to 9 completes -> busy_o[9] stays 1; rsv_conflict_o=0.
- Reserve addr 12 twice on consecutive edges, no writes -> rsv_conflict_o pulses 1 for exactly one cycle after the second; busy_o[12]=1.
- Assert rst asynchronously mid-cycle while requests are valid and busy_o=0x0000_1200 -> immediately rf_we_o=0 and busy_o=0; after release, both requesters valid -> requester 0 granted first.
